// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear controller for a 2-digit BCD counter: synchronized, debounced buttons,
// IDLE/RUN/PAUSE sequencing and a prescaled tick. Optional down-count via `COUNT_DOWN_EN (SW16).
module bcd_stopwatch_ctrl #(
   parameter int unsigned DEB_CYCLES = 1_000_000,
   parameter int unsigned TICK_DIV   = 50_000_000
) (
   input  logic       PIN_Y2,
   input  logic       KEY_0,
   input  logic       KEY_3,
   input  logic       KEY_2,
`ifdef COUNT_DOWN_EN
   input  logic       SW16,
`endif
   output logic [3:0] ONES,
   output logic [3:0] TENS,
   output logic       RUNNING,
   output logic       WRAP
);

   localparam int unsigned DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

   state_t        state, state_nx;
   logic [1:0]    sync_a, sync_b, acc, acc_d, press;
   logic [DW-1:0] deb_cnt [2];
   logic [PW-1:0] pre;
   logic          start_p, clr_p, tick, down;
   logic [3:0]    ones_nx, tens_nx;
   logic          wrap_nx;

   // Bit 0 = start/stop (KEY_3), bit 1 = clear (KEY_2); all idle high.
   always_ff @(posedge PIN_Y2 or negedge KEY_0) begin
      if (!KEY_0) begin
         sync_a <= '1;
         sync_b <= '1;
         acc    <= '1;
         acc_d  <= '1;
         for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
      end else begin
         sync_a <= {KEY_2, KEY_3};
         sync_b <= sync_a;
         acc_d  <= acc;
         for (int unsigned i = 0; i < 2; i++) begin
            if (sync_b[i] == acc[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
               acc[i]     <= sync_b[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
      end
   end

   assign press   = acc_d & ~acc;
   assign start_p = press[0];
   assign clr_p   = press[1];

`ifdef COUNT_DOWN_EN
   logic [1:0] sw_sync;
   always_ff @(posedge PIN_Y2 or negedge KEY_0) begin
      if (!KEY_0) sw_sync <= '0;
      else        sw_sync <= {sw_sync[0], SW16};
   end
   assign down = sw_sync[1];
`else
   assign down = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      if (clr_p) begin
         state_nx = S_IDLE;
      end else if (start_p) begin
         case (state)
            S_IDLE:  state_nx = S_RUN;
            S_RUN:   state_nx = S_PAUSE;
            S_PAUSE: state_nx = S_RUN;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge PIN_Y2 or negedge KEY_0) begin
      if (!KEY_0) begin
         state   <= S_IDLE;
         RUNNING <= 1'b0;
      end else begin
         state   <= state_nx;
         RUNNING <= (state_nx == S_RUN);
      end
   end

   assign tick = (state == S_RUN) && (pre == PW'(TICK_DIV - 1));

   // Prescaler holds its phase through PAUSE so a resume continues the current second.
   always_ff @(posedge PIN_Y2 or negedge KEY_0) begin
      if (!KEY_0)                         pre <= '0;
      else if (clr_p || state == S_IDLE)  pre <= '0;
      else if (state == S_RUN)            pre <= tick ? '0 : pre + PW'(1);
   end

   always_comb begin
      ones_nx = ONES;
      tens_nx = TENS;
      wrap_nx = 1'b0;
      if (clr_p) begin
         ones_nx = '0;
         tens_nx = '0;
      end else if (tick) begin
         if (!down) begin
            if (ONES == 4'd9) begin
               ones_nx = '0;
               if (TENS == 4'd9) begin
                  tens_nx = '0;
                  wrap_nx = 1'b1;
               end else begin
                  tens_nx = TENS + 4'd1;
               end
            end else begin
               ones_nx = ONES + 4'd1;
            end
         end else begin
            if (ONES == 4'd0) begin
               ones_nx = 4'd9;
               if (TENS == 4'd0) begin
                  tens_nx = 4'd9;
                  wrap_nx = 1'b1;
               end else begin
                  tens_nx = TENS - 4'd1;
               end
            end else begin
               ones_nx = ONES - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge PIN_Y2 or negedge KEY_0) begin
      if (!KEY_0) begin
         ONES <= '0;
         TENS <= '0;
         WRAP <= 1'b0;
      end else begin
         ONES <= ones_nx;
         TENS <= tens_nx;
         WRAP <= wrap_nx;
      end
   end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench for bcd_stopwatch_ctrl with DEB_CYCLES=4, TICK_DIV=5.
// Define COUNT_DOWN_EN to also exercise the SW16 down-count path.
module tb_bcd_stopwatch_ctrl;

   logic       clk;
   logic       KEY_0, KEY_3, KEY_2;
`ifdef COUNT_DOWN_EN
   logic       SW16;
`endif
   logic [3:0] ONES, TENS;
   logic       RUNNING, WRAP;

   bcd_stopwatch_ctrl #(.DEB_CYCLES(4), .TICK_DIV(5)) dut (
      .PIN_Y2  (clk),
      .KEY_0   (KEY_0),
      .KEY_3   (KEY_3),
      .KEY_2   (KEY_2),
`ifdef COUNT_DOWN_EN
      .SW16    (SW16),
`endif
      .ONES    (ONES),
      .TENS    (TENS),
      .RUNNING (RUNNING),
      .WRAP    (WRAP)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [9:0] val;   // {RUNNING, WRAP, TENS, ONES}
   } exp_t;

   exp_t sb_q[$];
   int   n_total = 0;
   int   n_bad   = 0;
   int   wrap_total = 0;
   int   max_ones = 0;
   int   max_tens = 0;
   int   w0;

   always @(negedge clk) begin
      if (WRAP === 1'b1) wrap_total++;
      if (int'(ONES) > max_ones) max_ones = int'(ONES);
      if (int'(TENS) > max_tens) max_tens = int'(TENS);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic sb_push(input string tag, input logic run, input logic wrap,
                          input logic [3:0] tens, input logic [3:0] ones);
      exp_t e;
      e.tag = tag;
      e.val = {run, wrap, tens, ones};
      sb_q.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
      end else begin
         e.tag = "sb_underflow";
         e.val = 'x;
      end
      check(e.tag, {22'd0, RUNNING, WRAP, TENS, ONES}, {22'd0, e.val});
   endtask

   task automatic wait_running(input logic want, input string tag);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (RUNNING === want) break;
      end
      check(tag, {31'd0, RUNNING}, {31'd0, want});
   endtask

   task automatic do_clear();
      sb_push("clear", 0, 0, 4'd0, 4'd0);
      KEY_2 = 1'b0;
      repeat (8) @(negedge clk);
      KEY_2 = 1'b1;
      repeat (8) @(negedge clk);
      sb_check();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      KEY_0 = 1'b0;
      KEY_3 = 1'b1;
      KEY_2 = 1'b1;
`ifdef COUNT_DOWN_EN
      SW16  = 1'b0;
`endif
      sb_push("reset", 0, 0, 4'd0, 4'd0);
      repeat (3) @(negedge clk);
      sb_check();
      KEY_0 = 1'b1;
      repeat (2) @(negedge clk);

      // bounce: low for only two sampled cycles
      sb_push("bounce", 0, 0, 4'd0, 4'd0);
      KEY_3 = 1'b0;
      repeat (2) @(negedge clk);
      KEY_3 = 1'b1;
      repeat (12) @(negedge clk);
      sb_check();

      // long held press, then count 250 cycles
      sb_push("hold_no_repeat", 1, 0, 4'd0, 4'd6);
      sb_push("count_49", 1, 0, 4'd4, 4'd9);
      sb_push("count_50", 1, 0, 4'd5, 4'd0);
      KEY_3 = 1'b0;
      wait_running(1'b1, "start_run");
      for (int i = 1; i <= 250; i++) begin
         @(negedge clk);
         if (i == 30) begin
            sb_check();
            KEY_3 = 1'b1;
         end
         if (i == 249 || i == 250) sb_check();
      end

      // full wrap 99 -> 00
      do_clear();
      sb_push("pre_wrap", 1, 0, 4'd9, 4'd9);
      sb_push("wrap", 1, 1, 4'd0, 4'd0);
      sb_push("post_wrap", 1, 0, 4'd0, 4'd0);
      sb_push("after_wrap", 1, 0, 4'd0, 4'd1);
      KEY_3 = 1'b0;
      wait_running(1'b1, "start_wrap");
      KEY_3 = 1'b1;
      w0 = wrap_total;
      for (int i = 1; i <= 505; i++) begin
         @(negedge clk);
         if (i == 499 || i == 500 || i == 501 || i == 505) sb_check();
      end
      check("wrap_pulses", wrap_total - w0, 1);

      // pause two cycles into a prescale period, hold, resume
      do_clear();
      sb_push("tick1", 1, 0, 4'd0, 4'd1);
      sb_push("pre_pause", 1, 0, 4'd0, 4'd2);
      sb_push("paused", 0, 0, 4'd0, 4'd2);
      sb_push("frozen", 0, 0, 4'd0, 4'd2);
      KEY_3 = 1'b0;
      wait_running(1'b1, "start_pause");
      KEY_3 = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         if (i == 5) begin
            sb_check();
            KEY_3 = 1'b0;
         end
         if (i == 11 || i == 12 || i == 32) sb_check();
         if (i == 13) KEY_3 = 1'b1;
      end
      sb_push("resume_hold", 1, 0, 4'd0, 4'd2);
      sb_push("resume_tick", 1, 0, 4'd0, 4'd3);
      KEY_3 = 1'b0;
      wait_running(1'b1, "resume");
      KEY_3 = 1'b1;
      repeat (2) @(negedge clk);
      sb_check();
      @(negedge clk);
      sb_check();

      // clear and start in the same cycle while running
      repeat (10) @(negedge clk);
      sb_push("clr_wins", 0, 0, 4'd0, 4'd0);
      sb_push("idle_hold", 0, 0, 4'd0, 4'd0);
      KEY_2 = 1'b0;
      KEY_3 = 1'b0;
      repeat (8) @(negedge clk);
      KEY_2 = 1'b1;
      KEY_3 = 1'b1;
      repeat (10) @(negedge clk);
      sb_check();
      repeat (20) @(negedge clk);
      sb_check();

      // asynchronous reset mid-run
      sb_push("async_reset", 0, 0, 4'd0, 4'd0);
      sb_push("post_reset", 0, 0, 4'd0, 4'd0);
      KEY_3 = 1'b0;
      wait_running(1'b1, "start_rst");
      KEY_3 = 1'b1;
      repeat (12) @(negedge clk);
      #2;
      KEY_0 = 1'b0;
      #1;
      sb_check();
      repeat (2) @(negedge clk);
      KEY_0 = 1'b1;
      repeat (10) @(negedge clk);
      sb_check();

`ifdef COUNT_DOWN_EN
      // down-count from 00, then flip direction mid-run
      SW16 = 1'b1;
      repeat (4) @(negedge clk);
      sb_push("down_pre", 1, 0, 4'd0, 4'd0);
      sb_push("down_wrap", 1, 1, 4'd9, 4'd9);
      sb_push("down_hold", 1, 0, 4'd9, 4'd9);
      sb_push("down_98", 1, 0, 4'd9, 4'd8);
      sb_push("dir_up", 1, 0, 4'd9, 4'd9);
      w0 = wrap_total;
      KEY_3 = 1'b0;
      wait_running(1'b1, "start_down");
      KEY_3 = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (i == 4 || i == 5 || i == 6 || i == 10 || i == 15) sb_check();
         if (i == 10) SW16 = 1'b0;
      end
      check("down_wrap_pulses", wrap_total - w0, 1);
`endif

      check("ones_range", {31'd0, max_ones > 9}, 32'd0);
      check("tens_range", {31'd0, max_tens > 9}, 32'd0);
      check("sb_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
